// File: rtl/bus_stream_bridge.sv
// Bus slave that bridges the CPU word bus to a pair of 32-bit valid/ready
// stream ports. A TX FIFO is filled by bus writes and drained by the stream
// consumer. An RX FIFO is filled by the stream producer and drained by bus
// reads. Every accepted access gets a registered one-cycle active-low rdy_.
module bus_stream_bridge #(
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [1:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_,
    output logic        irq,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;

    logic [31:0]   tx_mem_q [DEPTH];
    logic [31:0]   tx_mem_d [DEPTH];
    logic [31:0]   rx_mem_q [DEPTH];
    logic [31:0]   rx_mem_d [DEPTH];
    logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic          tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
    logic          rdy_n_q, rdy_n_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          irq_q, irq_d;

    logic          acc, tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          tx_wr_req, rx_rd_req, stat_wr, ctrl_wr;
    logic [31:0]   status;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(DEPTH));

    // Stream-side outputs are combinational from FIFO state; tx_data is show-ahead.
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_empty ? 32'h0 : tx_mem_q[tx_rp_q];
    assign rx_ready = ~rx_full;

    assign rd_data = rd_data_q;
    assign rdy_    = rdy_n_q;
    assign irq     = irq_q;

    // Decode the access, apply FIFO/register side effects and build the bus response.
    always_comb begin
        acc       = ~cs_ & ~as_;
        tx_wr_req = acc & ~rw & (addr == 2'd2);
        rx_rd_req = acc &  rw & (addr == 2'd3);
        stat_wr   = acc & ~rw & (addr == 2'd1);
        ctrl_wr   = acc & ~rw & (addr == 2'd0);

        // Fullness/emptiness is judged on pre-edge state, so a same-edge
        // stream pop never rescues an overflowing bus write.
        tx_push = tx_wr_req & ~tx_full;
        tx_pop  = tx_valid & tx_ready;
        rx_push = rx_valid & rx_ready;
        rx_pop  = rx_rd_req & ~rx_empty;

        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        if (tx_push) tx_mem_d[tx_wp_q] = wr_data;
        if (rx_push) rx_mem_d[rx_wp_q] = rx_data;

        tx_wp_d  = tx_push ? tx_wp_q + PW'(1) : tx_wp_q;
        tx_rp_d  = tx_pop  ? tx_rp_q + PW'(1) : tx_rp_q;
        rx_wp_d  = rx_push ? rx_wp_q + PW'(1) : rx_wp_q;
        rx_rp_d  = rx_pop  ? rx_rp_q + PW'(1) : rx_rp_q;

        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CW'(1);
        if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CW'(1);
        if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);

        ctrl_d = ctrl_wr ? wr_data[2:0] : ctrl_q;

        // A set on the same edge as a write-1-to-clear wins.
        tx_ovf_d = (tx_wr_req & tx_full)  | (tx_ovf_q & ~(stat_wr & wr_data[4]));
        rx_udf_d = (rx_rd_req & rx_empty) | (rx_udf_q & ~(stat_wr & wr_data[5]));

        status = {12'h0, 4'(tx_cnt_q), 4'h0, 4'(rx_cnt_q), 2'b00,
                  rx_udf_q, tx_ovf_q, tx_full, tx_empty, rx_full, rx_empty};

        rd_data_d = 32'h0;
        if (acc && rw) begin
            case (addr)
                2'd0:    rd_data_d = {29'h0, ctrl_q};
                2'd1:    rd_data_d = status;
                2'd3:    rd_data_d = rx_empty ? 32'h0 : rx_mem_q[rx_rp_q];
                default: rd_data_d = 32'h0;
            endcase
        end
        rdy_n_d = ~acc;

        // irq follows the state as it stands now, so it lags each change by one edge.
        irq_d = (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty) |
                (ctrl_q[2] & (tx_ovf_q | rx_udf_q));
    end

    // Control, pointer, flag and bus-response registers; reset aborts any access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            ctrl_q    <= '0;
            tx_ovf_q  <= 1'b0;
            rx_udf_q  <= 1'b0;
            rdy_n_q   <= 1'b1;
            rd_data_q <= 32'h0;
            irq_q     <= 1'b0;
        end else begin
            tx_wp_q   <= tx_wp_d;
            tx_rp_q   <= tx_rp_d;
            rx_wp_q   <= rx_wp_d;
            rx_rp_q   <= rx_rp_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            ctrl_q    <= ctrl_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_udf_q  <= rx_udf_d;
            rdy_n_q   <= rdy_n_d;
            rd_data_q <= rd_data_d;
            irq_q     <= irq_d;
        end
    end

    // FIFO storage needs no reset: zeroed counts make stale words unreachable.
    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

endmodule
